reg_fifo: RTL
=============

// Module: reg_fifo
// PURPOSE
//   Synchronous register-array FIFO built on the team's edge-triggered D flip-flop storage style.
//   Buffers DATA_W-bit words between a producer and a consumer on one clock.
//   Sits in the memory path directly after the flip-flop/latch register layer.
//   Turns raw per-bit storage into a flow-controlled queue.
// PARAMETERS
//   DATA_W  8  width of each stored word in bits (>=1)
//   DEPTH   8  number of entries; must be a power of two, >=2
//   ADDR_W  3  log2(DEPTH); must match DEPTH (checked in simulation)
// PORTS
//   clk       in   1       rising-edge clock; all state updates on posedge
//   rst_n     in   1       synchronous, active-low reset; sampled on posedge clk
//   wr_en     in   1       write request
//   wr_data   in   DATA_W  word to enqueue; sampled when the write is accepted
//   rd_en     in   1       read request
//   rd_data   out  DATA_W  dequeued word; registered
//   rd_valid  out  1       1-cycle pulse: rd_data holds a newly dequeued word
//   full      out  1       no free entry
//   empty     out  1       no stored entry
//   wr_err    out  1       1-cycle pulse: write attempted while full (dropped)
//   rd_err    out  1       1-cycle pulse: read attempted while empty (ignored)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge), synchronous only:
//     wr_ptr=0, rd_ptr=0, empty=1, full=0, rd_data=0, rd_valid=0, wr_err=0, rd_err=0.
//     Storage array is not reset.
//     Reset overrides any concurrent wr_en/rd_en; a reset mid-stream discards all contents.
// - Pointers are ADDR_W+1 bits; the low ADDR_W bits index the array and the MSB marks wrap.
//     empty = (wr_ptr == rd_ptr)
//     full  = (low bits equal) && (MSBs differ)
//     Both flags are derived from registered pointers, so they are valid in the same cycle the pointers update.
// - Write accept: wr_acc = wr_en & ~full.
//     On posedge: mem[wr_ptr[ADDR_W-1:0]] <= wr_data; wr_ptr <= wr_ptr+1 (modulo 2^(ADDR_W+1)).
// - Read accept: rd_acc = rd_en & ~empty.
//     On posedge: rd_data <= mem[rd_ptr[ADDR_W-1:0]]; rd_ptr <= rd_ptr+1; rd_valid <= 1.
//     Otherwise rd_valid <= 0 and rd_data holds its last value.
//     Read latency: one cycle from an accepted rd_en to rd_valid/rd_data.
// - Flags use the pre-edge values:
//     full and wr_en: write dropped, wr_err=1 next cycle, even if rd_acc occurs in the same cycle.
//     empty and rd_en: read ignored, rd_err=1 next cycle, even if wr_acc occurs in the same cycle.
// - Simultaneous wr_acc & rd_acc (neither full nor empty): both pointers advance, occupancy is unchanged.
// - Write-then-read ordering is strict FIFO. A word written at edge N is readable by rd_en sampled at edge N+1.
// - Pointer wrap: after 2*DEPTH accepted writes, wr_ptr returns to 0 with no glitch on the flags.
// CONFIGURATION
// - Macro REG_FIFO_COUNT_EN.
// - Defined: adds output port `count` (ADDR_W+1 bits) = wr_ptr - rd_ptr, registered.
//     Range 0..DEPTH; reset value 0; updated on the same edge as the pointers.
// - Undefined: the `count` port and its logic are absent. All other behaviour is identical.
// TESTING
// 1. Reset: hold rst_n=0 for 2 clk with wr_en=1, rd_en=1
//      -> empty=1, full=0, rd_valid=0, rd_data=0, wr_err=0, rd_err=0 (count=0 if EN).
// 2. Fill/drain: write 0x01..0x08 (DEPTH=8)
//      -> full=1 after the 8th edge; then read 8 times -> rd_data 0x01..0x08 in order, one cycle after each rd_en; empty=1 at the end.
// 3. Overflow/underflow: with full=1 assert wr_en and rd_en together
//      -> read returns the oldest word, write dropped, wr_err=1 for one cycle.
//      With empty=1 assert both -> write stored, rd_err=1, rd_valid=0.
// 4. Streaming: hold wr_en=rd_en=1 for 40 cycles after preloading 3 words
//      -> occupancy stays 3; data out equals data in delayed by 3 reads; pointers wrap with no flag glitch.
// 5. Mid-operation reset: pulse rst_n=0 for 1 cycle when 5 words are stored
//      -> next cycle empty=1; a following read gives rd_err=1; a new write/read returns the new word.
// 6. REG_FIFO_COUNT_EN build: write 3, read 1, simultaneous write+read
//      -> count sequence 1,2,3,2,2.

Source files
------------

// File: rtl/reg_fifo.sv
// Register-array FIFO: DEPTH x DATA_W flip-flop storage with registered read port and error pulses.
// Optional REG_FIFO_COUNT_EN adds a registered occupancy output `count`.
module reg_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              wr_err,
`ifdef REG_FIFO_COUNT_EN
    output logic [ADDR_W:0]   count,
`endif
    output logic              rd_err
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;
    logic              wr_err_q;
    logic              rd_err_q;
    logic              wr_acc;
    logic              rd_acc;

    // Extra pointer MSB distinguishes a full wrap from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_acc;
            wr_err_q   <= wr_en & full;
            rd_err_q   <= rd_en & empty;
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wr_err   = wr_err_q;
    assign rd_err   = rd_err_q;

`ifdef REG_FIFO_COUNT_EN
    logic [ADDR_W:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (DEPTH == (32'd1 << ADDR_W))
        else $error("reg_fifo: ADDR_W does not match DEPTH");
    end
`endif

endmodule
